// File: rtl/column_count_resolver_pkg.sv
// Shared types and sizing helpers for the column count resolver.
// Imported by the segment adder and by the resolver top level.
package column_count_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int COUNT_W      = 3;
    localparam int CARRY_W      = 3;
    localparam int DEF_NUM_COLS = 64;
    localparam int DEF_SEG_COLS = 16;

    function automatic int num_segments(input int num_cols, input int seg_cols);
        return num_cols / seg_cols;
    endfunction

    // A single-segment configuration still needs a 1-bit index register.
    function automatic int seg_idx_width(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/column_count_resolver_segment_adder.sv
// Combinational weighted sum of one segment of column counts plus an incoming carry.
// The adder splits the total into the segment's binary sum bits and the carry into the next segment.
module column_segment_adder
    import column_count_resolver_pkg::*;
#(
    parameter int SEG_COLS = DEF_SEG_COLS
) (
    input  logic [COUNT_W*SEG_COLS-1:0] seg_counts_i,
    input  logic [CARRY_W-1:0]          carry_i,
    output logic [SEG_COLS-1:0]         sum_o,
    output logic [CARRY_W-1:0]          carry_o
);

    // 7*(2^SEG_COLS - 1) + 7 == 7*2^SEG_COLS, so SEG_COLS+3 bits always hold the total.
    localparam int ACC_W = SEG_COLS + CARRY_W;

    logic [ACC_W-1:0] acc;

    always_comb begin
        acc = ACC_W'(carry_i);
        for (int j = 0; j < SEG_COLS; j++) begin
            acc = acc + (ACC_W'(seg_counts_i[j*COUNT_W +: COUNT_W]) << j);
        end
    end

    assign sum_o   = acc[SEG_COLS-1:0];
    assign carry_o = acc[ACC_W-1:SEG_COLS];

endmodule

// File: rtl/column_count_resolver.sv
// Resolves a vector of per-column 3-bit counts into a binary sum, one segment per cycle,
// with a valid/ready handshake on both sides.
module column_count_resolver
    import column_count_resolver_pkg::*;
#(
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int SEG_COLS = DEF_SEG_COLS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [COUNT_W*NUM_COLS-1:0] in_counts,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_COLS+CARRY_W-1:0] out_sum
);

    localparam int NSEG      = num_segments(NUM_COLS, SEG_COLS);
    localparam int SEG_IDX_W = seg_idx_width(NSEG);
    localparam int SEG_BITS  = COUNT_W * SEG_COLS;
    localparam int SUM_W     = NUM_COLS + CARRY_W;

    state_e                      state_q, state_d;
    logic [SEG_IDX_W-1:0]        seg_idx_q, seg_idx_d;
    logic [CARRY_W-1:0]          carry_q, carry_d;
    logic [COUNT_W*NUM_COLS-1:0] counts_q, counts_d;
    logic [SUM_W-1:0]            sum_q, sum_d;

    logic [SEG_BITS-1:0]         seg_counts;
    logic [SEG_COLS-1:0]         seg_sum;
    logic [CARRY_W-1:0]          seg_carry;
    logic                        accept;
    logic                        last_seg;

    assign in_ready  = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign last_seg  = (seg_idx_q == SEG_IDX_W'(NSEG - 1));

    always_comb begin
        seg_counts = '0;
        for (int s = 0; s < NSEG; s++) begin
            if (seg_idx_q == SEG_IDX_W'(s)) begin
                seg_counts = counts_q[s*SEG_BITS +: SEG_BITS];
            end
        end
    end

    column_segment_adder #(
        .SEG_COLS (SEG_COLS)
    ) u_segment_adder (
        .seg_counts_i (seg_counts),
        .carry_i      (carry_q),
        .sum_o        (seg_sum),
        .carry_o      (seg_carry)
    );

    always_comb begin
        state_d   = state_q;
        seg_idx_d = seg_idx_q;
        carry_d   = carry_q;
        counts_d  = counts_q;
        sum_d     = sum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    counts_d  = in_counts;
                    seg_idx_d = '0;
                    carry_d   = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int s = 0; s < NSEG; s++) begin
                    if (seg_idx_q == SEG_IDX_W'(s)) begin
                        sum_d[s*SEG_COLS +: SEG_COLS] = seg_sum;
                    end
                end
                carry_d   = seg_carry;
                seg_idx_d = seg_idx_q + 1'b1;
                if (last_seg) begin
                    sum_d[NUM_COLS +: CARRY_W] = seg_carry;
                    seg_idx_d                  = '0;
                    state_d                    = ST_DONE;
                end
            end
            ST_DONE: begin
                // Accepting here lets the next vector start without an IDLE bubble.
                if (out_ready) begin
                    if (accept) begin
                        counts_d  = in_counts;
                        seg_idx_d = '0;
                        carry_d   = '0;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            seg_idx_q <= '0;
            carry_q   <= '0;
            counts_q  <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            carry_q   <= carry_d;
            counts_q  <= counts_d;
            sum_q     <= sum_d;
        end
    end

endmodule

// File: tb/tb_column_count_resolver.sv
// Directed testbench for column_count_resolver with default parameters.
// Each scenario task drives its own stimulus and checks against hand-computed sums.
module tb_column_count_resolver;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [191:0] in_counts;
    logic         out_valid;
    logic         out_ready;
    logic [66:0]  out_sum;

    int checks;
    int failures;

    column_count_resolver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_counts (in_counts),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [191:0] fill_counts(input logic [2:0] v);
        logic [191:0] c;
        for (int i = 0; i < 64; i++) begin
            c[3*i +: 3] = v;
        end
        return c;
    endfunction

    // Waits for in_ready, accepts one vector, then counts edges until out_valid.
    task automatic applyStimulus(input logic [191:0] counts, output int latency);
        int waited;
        @(negedge clk);
        in_valid  = 1'b1;
        in_counts = counts;
        waited    = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 20) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vector(input string name, input logic [191:0] counts,
                              input logic [66:0] expected);
        int lat;
        applyStimulus(counts, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d required 4", name, lat);
        end
        checks++;
        if (out_sum !== expected) begin
            failures++;
            $display("[TB] FAIL %s_sum: got 0x%0h required 0x%0h", name, out_sum, expected);
        end
        consume();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_counts = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 67'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: out_valid=%0b in_ready=%0b out_sum=0x%0h required 0 0 0",
                     out_valid, in_ready, out_sum);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        run_vector("all_zero", '0, 67'd0);
    endtask

    task automatic test_single_column();
        logic [191:0] c;
        c = '0;
        c[2:0] = 3'd6;
        run_vector("col0_six", c, 67'd6);
    endtask

    task automatic test_segment_carry();
        logic [191:0] c;
        c = '0;
        c[3*15 +: 3] = 3'd3;
        c[3*16 +: 3] = 3'd1;
        run_vector("seg_boundary", c, 67'h28000);
    endtask

    task automatic test_saturated_columns();
        run_vector("all_six", fill_counts(3'd6), 67'h5FFFFFFFFFFFFFFFA);
        run_vector("all_seven", fill_counts(3'd7), 67'h6FFFFFFFFFFFFFFF9);
    endtask

    task automatic test_back_to_back();
        logic [191:0] a;
        logic [191:0] b;
        int lat;
        a = '0;
        a[3*3 +: 3] = 3'd5;
        b = '0;
        b[3*1 +: 3] = 3'd1;
        applyStimulus(a, lat);
        checks++;
        if (lat !== 4 || out_sum !== 67'd40) begin
            failures++;
            $display("[TB] FAIL bp_first: latency=%0d sum=0x%0h required 4 0x28", lat, out_sum);
        end
        // A new vector offered while out_ready is low must be ignored.
        @(negedge clk);
        in_valid  = 1'b1;
        in_counts = b;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 67'd40 || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d: out_valid=%0b sum=0x%0h in_ready=%0b required 1 0x28 0",
                         k, out_valid, out_sum, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_run: out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || out_sum !== 67'd2) begin
            failures++;
            $display("[TB] FAIL b2b_second: latency=%0d sum=0x%0h required 4 0x2", lat, out_sum);
        end
        consume();
    endtask

    task automatic test_reset_midrun();
        logic [191:0] c;
        @(negedge clk);
        in_valid  = 1'b1;
        in_counts = fill_counts(3'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 67'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: out_valid=%0b in_ready=%0b sum=0x%0h required 0 0 0",
                     out_valid, in_ready, out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL post_reset_idle%0d: out_valid=%0b in_ready=%0b required 0 1",
                         k, out_valid, in_ready);
            end
        end
        c = '0;
        c[3*63 +: 3] = 3'd1;
        run_vector("col63", c, 67'h8000000000000000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_single_column();
        test_segment_carry();
        test_saturated_columns();
        test_back_to_back();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
